mult_div_unit: RTL

//  E-stage HI/LO multiply/divide unit; consumes the decoder's Multiop/start controls.

---
 rtl/md_defs.sv | 22 ++
 rtl/mult_div_unit_if.sv | 34 +++
 rtl/md_arith.sv | 47 ++++
 rtl/mult_div_unit.sv | 108 ++++++++++
 4 files changed

// File: rtl/md_defs.sv
// Shared definitions for the HI/LO multiply/divide unit:
// multiop encodings, default latencies and FSM states.
package md_defs;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;
    localparam logic [2:0] MD_MFHI  = 3'b111;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage <-> mult/div unit control and result bundle.
// MD_FLUSH_EN adds the flush strobe.
interface mult_div_unit_if;

    logic        start;
    logic        hilo_we;
    logic [2:0]  multiop;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MD_FLUSH_EN
    logic        flush;
`endif
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, hilo_we, multiop, a, b,
`ifdef MD_FLUSH_EN
        output flush,
`endif
        input  busy, rd_data, hi, lo
    );

    modport slave (
        input  start, hilo_we, multiop, a, b,
`ifdef MD_FLUSH_EN
        input  flush,
`endif
        output busy, rd_data, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// Combinational 32x32 product and quotient/remainder.
// res_we is low for a divide by zero so HI/LO are left alone.
module md_arith (
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        res_we
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide on magnitudes; 0x80000000/-1 wraps back to 0x80000000.
    assign sdiv  = (op == 2'b10);
    assign mag_a = (sdiv && a[31]) ? -a : a;
    assign mag_b = (sdiv && b[31]) ? -b : b;
    assign div_b = (b == 32'd0) ? 32'd1 : mag_b;
    assign q_u   = mag_a / div_b;
    assign r_u   = mag_a % div_b;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        unique case (op)
            2'b00:   {hi_res, lo_res} = prod_s;
            2'b01:   {hi_res, lo_res} = prod_u;
            default: begin
                lo_res = (sdiv && (a[31] ^ b[31])) ? -q_u : q_u;
                hi_res = (sdiv && a[31]) ? -r_u : r_u;
            end
        endcase
    end

    assign res_we = !(op[1] && (b == 32'd0));

endmodule

// File: rtl/mult_div_unit.sv
// E-stage HI/LO multiply/divide unit with fixed-latency busy window.
// Define MD_FLUSH_EN to enable cancelling an in-flight op via flush.
module mult_div_unit
    import md_defs::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_div_unit_if.slave   bus
);

    md_state_e   state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] hi_tmp, lo_tmp;
    logic        tmp_we;
    logic        kill;
    logic        take;
    logic        commit;

`ifdef MD_FLUSH_EN
    assign kill = bus.flush;
`else
    assign kill = 1'b0;
`endif

    assign take   = (state == MD_IDLE) && bus.start && !kill;
    assign commit = (state == MD_RUN) && (cnt == 8'd1) && !kill;

    md_arith u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_res (hi_tmp),
        .lo_res (lo_tmp),
        .res_we (tmp_we)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            MD_IDLE: begin
                if (take) begin
                    state_d = MD_RUN;
                    cnt_d   = bus.multiop[1] ? 8'(DIV_LAT) : 8'(MULT_LAT);
                end
            end
            MD_RUN: begin
                if (kill) begin
                    state_d = MD_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt - 8'd1;
                    if (cnt == 8'd1) state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= 8'd0;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (take) begin
                op_q <= bus.multiop[1:0];
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
        end
    end

    // mthi/mtlo only land when idle and no start competes for the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (commit) begin
            if (tmp_we) begin
                hi_q <= hi_tmp;
                lo_q <= lo_tmp;
            end
        end else if ((state == MD_IDLE) && bus.hilo_we && !bus.start) begin
            if (bus.multiop == MD_MTHI) hi_q <= bus.a;
            if (bus.multiop == MD_MTLO) lo_q <= bus.a;
        end
    end

    assign bus.busy    = (state == MD_RUN);
    assign bus.rd_data = (bus.multiop == MD_MFHI) ? hi_q : lo_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule
